g_udp_rxbuf_ctrl: RTL and testbench

//  Ping-pong receive-buffer controller behind the 1G UDP receiver.
//  - Takes the receiver's 32-bit payload words and frame-end/abort pulses.
//  - Steers each frame into one of two RAM banks.
//  - Hands completed banks to a consumer with a valid/release handshake.
//  - Drops frames when no bank is free and counts good and dropped frames.

---
 rtl/g_udp_rxbuf_ctrl_if.sv | 38 +++
 rtl/g_udp_rxbuf_ctrl.sv | 140 ++++++++++++++
 tb/tb_g_udp_rxbuf_ctrl.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/g_udp_rxbuf_ctrl_if.sv
// Bundle of receiver-side, RAM write-port and consumer handshake signals
// for the ping-pong receive-buffer controller.
interface g_udp_rxbuf_ctrl_if #(
   parameter int ADDR_W = 9
);
   logic [31:0]     rx_word;
   logic            rx_word_valid;
   logic            rx_frame_done;
   logic            rx_frame_abort;
   logic [15:0]     rx_frame_len;
   logic            ram_we;
   logic [ADDR_W:0] ram_waddr;
   logic [31:0]     ram_wdata;
   logic            buf_valid;
   logic            buf_bank;
   logic [15:0]     buf_len;
   logic [ADDR_W:0] buf_words;
   logic            buf_release;
   logic            wr_busy;
   logic [15:0]     frames_ok;
   logic [15:0]     frames_dropped;

   modport slave (
      input  rx_word, rx_word_valid, rx_frame_done, rx_frame_abort, rx_frame_len,
      input  buf_release,
      output ram_we, ram_waddr, ram_wdata,
      output buf_valid, buf_bank, buf_len, buf_words,
      output wr_busy, frames_ok, frames_dropped
   );

   modport master (
      output rx_word, rx_word_valid, rx_frame_done, rx_frame_abort, rx_frame_len,
      output buf_release,
      input  ram_we, ram_waddr, ram_wdata,
      input  buf_valid, buf_bank, buf_len, buf_words,
      input  wr_busy, frames_ok, frames_dropped
   );
endinterface

// File: rtl/g_udp_rxbuf_ctrl.sv
// Ping-pong receive-buffer controller: steers frames into two RAM banks,
// offers committed banks in order to a consumer, counts good/dropped frames.
module g_udp_rxbuf_ctrl #(
   parameter int ADDR_W = 9
) (
   input  logic                 clk,
   input  logic                 clr,
   g_udp_rxbuf_ctrl_if.slave    bus
);
   typedef enum logic [1:0] {W_IDLE, W_FILL, W_DROP} w_state_t;

   localparam logic [ADDR_W:0] C_DEPTH = {1'b1, {ADDR_W{1'b0}}};

   w_state_t        r_state;
   logic [1:0]      r_bank_full;
   logic            r_wr_bank;
   logic            r_rd_bank;
   logic [ADDR_W:0] r_word_cnt;
   logic [15:0]     r_len   [2];
   logic [ADDR_W:0] r_words [2];
   logic            r_ram_we;
   logic [ADDR_W:0] r_ram_waddr;
   logic [31:0]     r_ram_wdata;
   logic [15:0]     r_frames_ok;
   logic [15:0]     r_frames_dropped;

   logic            w_release;
   logic [ADDR_W:0] w_words_commit;
   logic            w_overflow;

   assign w_release      = bus.buf_release & r_bank_full[r_rd_bank];
   // A word arriving with frame_done counts towards the committed length.
   assign w_words_commit = r_word_cnt + {{ADDR_W{1'b0}}, bus.rx_word_valid};
   assign w_overflow     = bus.rx_word_valid & (r_word_cnt == C_DEPTH);

   always_ff @(posedge clk) begin
      if (clr) begin
         r_state          <= W_IDLE;
         r_bank_full      <= 2'b00;
         r_wr_bank        <= 1'b0;
         r_rd_bank        <= 1'b0;
         r_word_cnt       <= '0;
         r_len[0]         <= '0;
         r_len[1]         <= '0;
         r_words[0]       <= '0;
         r_words[1]       <= '0;
         r_ram_we         <= 1'b0;
         r_ram_waddr      <= '0;
         r_ram_wdata      <= '0;
         r_frames_ok      <= '0;
         r_frames_dropped <= '0;
      end else begin
         r_ram_we <= 1'b0;

         if (w_release) begin
            r_bank_full[r_rd_bank] <= 1'b0;
            r_rd_bank              <= ~r_rd_bank;
         end

         case (r_state)
            W_IDLE: begin
               if (bus.rx_word_valid) begin
                  if (!r_bank_full[r_wr_bank]) begin
                     r_ram_we    <= 1'b1;
                     r_ram_waddr <= {r_wr_bank, {ADDR_W{1'b0}}};
                     r_ram_wdata <= bus.rx_word;
                     r_word_cnt  <= {{ADDR_W{1'b0}}, 1'b1};
                     if (bus.rx_frame_abort) begin
                        r_state <= W_IDLE;
                     end else if (bus.rx_frame_done) begin
                        r_bank_full[r_wr_bank] <= 1'b1;
                        r_len[r_wr_bank]       <= bus.rx_frame_len;
                        r_words[r_wr_bank]     <= {{ADDR_W{1'b0}}, 1'b1};
                        r_wr_bank              <= ~r_wr_bank;
                        r_frames_ok            <= r_frames_ok + 16'd1;
                        r_state                <= W_IDLE;
                     end else begin
                        r_state <= W_FILL;
                     end
                  end else if (bus.rx_frame_done || bus.rx_frame_abort) begin
                     r_frames_dropped <= r_frames_dropped + 16'd1;
                     r_state          <= W_IDLE;
                  end else begin
                     r_state <= W_DROP;
                  end
               end
            end

            W_FILL: begin
               if (bus.rx_frame_abort) begin
                  // Bank is left free and the next frame overwrites it.
                  r_state <= W_IDLE;
               end else if (w_overflow) begin
                  if (bus.rx_frame_done) begin
                     r_frames_dropped <= r_frames_dropped + 16'd1;
                     r_state          <= W_IDLE;
                  end else begin
                     r_state <= W_DROP;
                  end
               end else begin
                  if (bus.rx_word_valid) begin
                     r_ram_we    <= 1'b1;
                     r_ram_waddr <= {r_wr_bank, r_word_cnt[ADDR_W-1:0]};
                     r_ram_wdata <= bus.rx_word;
                     r_word_cnt  <= w_words_commit;
                  end
                  if (bus.rx_frame_done) begin
                     r_bank_full[r_wr_bank] <= 1'b1;
                     r_len[r_wr_bank]       <= bus.rx_frame_len;
                     r_words[r_wr_bank]     <= w_words_commit;
                     r_wr_bank              <= ~r_wr_bank;
                     r_frames_ok            <= r_frames_ok + 16'd1;
                     r_state                <= W_IDLE;
                  end
               end
            end

            W_DROP: begin
               if (bus.rx_frame_done || bus.rx_frame_abort) begin
                  r_frames_dropped <= r_frames_dropped + 16'd1;
                  r_state          <= W_IDLE;
               end
            end

            default: r_state <= W_IDLE;
         endcase
      end
   end

   assign bus.ram_we         = r_ram_we;
   assign bus.ram_waddr      = r_ram_waddr;
   assign bus.ram_wdata      = r_ram_wdata;
   assign bus.buf_valid      = r_bank_full[r_rd_bank];
   assign bus.buf_bank       = r_rd_bank;
   assign bus.buf_len        = r_len[r_rd_bank];
   assign bus.buf_words      = r_words[r_rd_bank];
   assign bus.wr_busy        = (r_state == W_FILL);
   assign bus.frames_ok      = r_frames_ok;
   assign bus.frames_dropped = r_frames_dropped;
endmodule

// File: tb/tb_g_udp_rxbuf_ctrl.sv
// Directed bench for g_udp_rxbuf_ctrl: a vector table for the main flows plus
// hand-written sequences for bank overflow and mid-frame clear.
module tb_g_udp_rxbuf_ctrl;
   localparam int ADDR_W = 9;

   logic clk = 1'b0;
   logic clr = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   g_udp_rxbuf_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

   g_udp_rxbuf_ctrl #(.ADDR_W(ADDR_W)) dut (
      .clk (clk),
      .clr (clr),
      .bus (bus)
   );

   typedef struct {
      logic        wv;
      logic [31:0] wd;
      logic        dn;
      logic        ab;
      logic [15:0] len;
      logic        rel;
      logic        we;
      logic [9:0]  wa;
      logic [31:0] wdat;
      logic        bv;
      logic        bb;
      logic [15:0] blen;
      logic [9:0]  bw;
      logic [15:0] ok;
      logic [15:0] dr;
      logic        busy;
   } vec_t;

   vec_t vecs [19];

   function automatic vec_t mk(input logic wv, input logic [31:0] wd, input logic dn,
                               input logic ab, input logic [15:0] len, input logic rel,
                               input logic we, input logic [9:0] wa, input logic [31:0] wdat,
                               input logic bv, input logic bb, input logic [15:0] blen,
                               input logic [9:0] bw, input logic [15:0] ok,
                               input logic [15:0] dr, input logic busy);
      vec_t v;
      v.wv = wv; v.wd = wd; v.dn = dn; v.ab = ab; v.len = len; v.rel = rel;
      v.we = we; v.wa = wa; v.wdat = wdat; v.bv = bv; v.bb = bb; v.blen = blen;
      v.bw = bw; v.ok = ok; v.dr = dr; v.busy = busy;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic wv, input logic [31:0] wd, input logic dn,
                        input logic ab, input logic [15:0] len, input logic rel);
      bus.rx_word_valid  = wv;
      bus.rx_word        = wd;
      bus.rx_frame_done  = dn;
      bus.rx_frame_abort = ab;
      bus.rx_frame_len   = len;
      bus.buf_release    = rel;
      @(posedge clk);
      #1;
      bus.rx_word_valid  = 1'b0;
      bus.rx_word        = '0;
      bus.rx_frame_done  = 1'b0;
      bus.rx_frame_abort = 1'b0;
      bus.rx_frame_len   = '0;
      bus.buf_release    = 1'b0;
   endtask

   task automatic apply(input int idx, input vec_t v);
      drive(v.wv, v.wd, v.dn, v.ab, v.len, v.rel);
      $display("vec %0d: wv=%0b dn=%0b ab=%0b rel=%0b -> we=%0b wa=%0h bv=%0b bb=%0b ok=%0d dr=%0d",
               idx, v.wv, v.dn, v.ab, v.rel, bus.ram_we, bus.ram_waddr, bus.buf_valid,
               bus.buf_bank, bus.frames_ok, bus.frames_dropped);
      chk($sformatf("v%0d ram_we", idx), 32'(bus.ram_we), 32'(v.we));
      if (v.we) begin
         chk($sformatf("v%0d ram_waddr", idx), 32'(bus.ram_waddr), 32'(v.wa));
         chk($sformatf("v%0d ram_wdata", idx), bus.ram_wdata, v.wdat);
      end
      chk($sformatf("v%0d buf_valid", idx), 32'(bus.buf_valid), 32'(v.bv));
      chk($sformatf("v%0d buf_bank", idx), 32'(bus.buf_bank), 32'(v.bb));
      if (v.bv) begin
         chk($sformatf("v%0d buf_len", idx), 32'(bus.buf_len), 32'(v.blen));
         chk($sformatf("v%0d buf_words", idx), 32'(bus.buf_words), 32'(v.bw));
      end
      chk($sformatf("v%0d frames_ok", idx), 32'(bus.frames_ok), 32'(v.ok));
      chk($sformatf("v%0d frames_dropped", idx), 32'(bus.frames_dropped), 32'(v.dr));
      chk($sformatf("v%0d wr_busy", idx), 32'(bus.wr_busy), 32'(v.busy));
   endtask

   initial begin
      int n_writes;
      bus.rx_word_valid  = 1'b0;
      bus.rx_word        = '0;
      bus.rx_frame_done  = 1'b0;
      bus.rx_frame_abort = 1'b0;
      bus.rx_frame_len   = '0;
      bus.buf_release    = 1'b0;

      // three words + done, second frame, dropped third, release, abort,
      // same-cycle commit/release, same-cycle word/done, lone abort
      vecs[0]  = mk(1, 32'hA0A0_0001, 0, 0, 0,  0, 1, 10'h000, 32'hA0A0_0001, 0, 0, 0,  0, 0, 0, 1);
      vecs[1]  = mk(1, 32'hB0B0_0002, 0, 0, 0,  0, 1, 10'h001, 32'hB0B0_0002, 0, 0, 0,  0, 0, 0, 1);
      vecs[2]  = mk(1, 32'hC0C0_0003, 0, 0, 0,  0, 1, 10'h002, 32'hC0C0_0003, 0, 0, 0,  0, 0, 0, 1);
      vecs[3]  = mk(0, 0,             1, 0, 20, 0, 0, 0,       0,             1, 0, 20, 3, 1, 0, 0);
      vecs[4]  = mk(1, 32'hD0D0_0004, 0, 0, 0,  0, 1, 10'h200, 32'hD0D0_0004, 1, 0, 20, 3, 1, 0, 1);
      vecs[5]  = mk(0, 0,             1, 0, 8,  0, 0, 0,       0,             1, 0, 20, 3, 2, 0, 0);
      vecs[6]  = mk(1, 32'hE0E0_0005, 0, 0, 0,  0, 0, 0,       0,             1, 0, 20, 3, 2, 0, 0);
      vecs[7]  = mk(1, 32'hF0F0_0006, 0, 0, 0,  0, 0, 0,       0,             1, 0, 20, 3, 2, 0, 0);
      vecs[8]  = mk(0, 0,             1, 0, 4,  0, 0, 0,       0,             1, 0, 20, 3, 2, 1, 0);
      vecs[9]  = mk(0, 0,             0, 0, 0,  1, 0, 0,       0,             1, 1, 8,  1, 2, 1, 0);
      vecs[10] = mk(1, 32'h1111_0007, 0, 0, 0,  0, 1, 10'h000, 32'h1111_0007, 1, 1, 8,  1, 2, 1, 1);
      vecs[11] = mk(1, 32'h2222_0008, 0, 0, 0,  0, 1, 10'h001, 32'h2222_0008, 1, 1, 8,  1, 2, 1, 1);
      vecs[12] = mk(0, 0,             0, 1, 0,  0, 0, 0,       0,             1, 1, 8,  1, 2, 1, 0);
      vecs[13] = mk(1, 32'h3333_0009, 0, 0, 0,  0, 1, 10'h000, 32'h3333_0009, 1, 1, 8,  1, 2, 1, 1);
      vecs[14] = mk(0, 0,             1, 0, 12, 1, 0, 0,       0,             1, 0, 12, 1, 3, 1, 0);
      vecs[15] = mk(0, 0,             0, 0, 0,  1, 0, 0,       0,             0, 1, 0,  0, 3, 1, 0);
      vecs[16] = mk(1, 32'h4444_000A, 1, 0, 4,  0, 1, 10'h200, 32'h4444_000A, 1, 1, 4,  1, 4, 1, 0);
      vecs[17] = mk(0, 0,             0, 1, 0,  0, 0, 0,       0,             1, 1, 4,  1, 4, 1, 0);
      vecs[18] = mk(0, 0,             0, 0, 0,  1, 0, 0,       0,             0, 0, 0,  0, 4, 1, 0);

      // reset state
      @(posedge clk);
      @(posedge clk);
      #1;
      clr = 1'b0;
      $display("reset: we=%0b bv=%0b ok=%0d dr=%0d", bus.ram_we, bus.buf_valid,
               bus.frames_ok, bus.frames_dropped);
      chk("rst ram_we", 32'(bus.ram_we), 32'd0);
      chk("rst buf_valid", 32'(bus.buf_valid), 32'd0);
      chk("rst frames_ok", 32'(bus.frames_ok), 32'd0);
      chk("rst frames_dropped", 32'(bus.frames_dropped), 32'd0);
      chk("rst wr_busy", 32'(bus.wr_busy), 32'd0);

      for (int i = 0; i < 19; i++) apply(i, vecs[i]);

      // 513 words into bank0: 512 writes, then overflow drops the frame
      n_writes = 0;
      for (int i = 0; i < 513; i++) begin
         drive(1'b1, 32'h5500_0000 + 32'(i), 1'b0, 1'b0, 16'd0, 1'b0);
         if (bus.ram_we) n_writes++;
         if (i < 512) begin
            chk($sformatf("ovf waddr %0d", i), 32'(bus.ram_waddr), 32'(i));
         end else begin
            chk("ovf we at word 513", 32'(bus.ram_we), 32'd0);
            chk("ovf busy after overflow", 32'(bus.wr_busy), 32'd0);
         end
      end
      drive(1'b0, 32'd0, 1'b1, 1'b0, 16'd2052, 1'b0);
      $display("overflow: writes=%0d ok=%0d dr=%0d bv=%0b", n_writes, bus.frames_ok,
               bus.frames_dropped, bus.buf_valid);
      chk("ovf write count", 32'(n_writes), 32'd512);
      chk("ovf frames_dropped", 32'(bus.frames_dropped), 32'd2);
      chk("ovf frames_ok", 32'(bus.frames_ok), 32'd4);
      chk("ovf buf_valid", 32'(bus.buf_valid), 32'd0);
      drive(1'b1, 32'h6666_000B, 1'b0, 1'b0, 16'd0, 1'b0);
      $display("post-ovf word: we=%0b wa=%0h", bus.ram_we, bus.ram_waddr);
      chk("post-ovf we", 32'(bus.ram_we), 32'd1);
      chk("post-ovf waddr", 32'(bus.ram_waddr), 32'h000);
      drive(1'b0, 32'd0, 1'b1, 1'b0, 16'd5, 1'b0);
      $display("post-ovf done: bv=%0b bb=%0b len=%0d words=%0d ok=%0d", bus.buf_valid,
               bus.buf_bank, bus.buf_len, bus.buf_words, bus.frames_ok);
      chk("post-ovf buf_valid", 32'(bus.buf_valid), 32'd1);
      chk("post-ovf buf_bank", 32'(bus.buf_bank), 32'd0);
      chk("post-ovf buf_len", 32'(bus.buf_len), 32'd5);
      chk("post-ovf buf_words", 32'(bus.buf_words), 32'd1);
      chk("post-ovf frames_ok", 32'(bus.frames_ok), 32'd5);

      // clear in the middle of a bank1 fill
      drive(1'b1, 32'h7777_000C, 1'b0, 1'b0, 16'd0, 1'b0);
      chk("clr pre waddr0", 32'(bus.ram_waddr), 32'h200);
      drive(1'b1, 32'h8888_000D, 1'b0, 1'b0, 16'd0, 1'b0);
      chk("clr pre waddr1", 32'(bus.ram_waddr), 32'h201);
      chk("clr pre busy", 32'(bus.wr_busy), 32'd1);
      clr = 1'b1;
      drive(1'b0, 32'd0, 1'b0, 1'b0, 16'd0, 1'b0);
      clr = 1'b0;
      $display("after clr: we=%0b bv=%0b bb=%0b ok=%0d dr=%0d busy=%0b", bus.ram_we,
               bus.buf_valid, bus.buf_bank, bus.frames_ok, bus.frames_dropped, bus.wr_busy);
      chk("clr ram_we", 32'(bus.ram_we), 32'd0);
      chk("clr ram_waddr", 32'(bus.ram_waddr), 32'd0);
      chk("clr ram_wdata", bus.ram_wdata, 32'd0);
      chk("clr buf_valid", 32'(bus.buf_valid), 32'd0);
      chk("clr buf_bank", 32'(bus.buf_bank), 32'd0);
      chk("clr buf_len", 32'(bus.buf_len), 32'd0);
      chk("clr buf_words", 32'(bus.buf_words), 32'd0);
      chk("clr frames_ok", 32'(bus.frames_ok), 32'd0);
      chk("clr frames_dropped", 32'(bus.frames_dropped), 32'd0);
      chk("clr wr_busy", 32'(bus.wr_busy), 32'd0);
      drive(1'b1, 32'h9999_000E, 1'b0, 1'b0, 16'd0, 1'b0);
      $display("post-clr word: we=%0b wa=%0h", bus.ram_we, bus.ram_waddr);
      chk("post-clr we", 32'(bus.ram_we), 32'd1);
      chk("post-clr waddr", 32'(bus.ram_waddr), 32'h000);
      chk("post-clr wdata", bus.ram_wdata, 32'h9999_000E);
      drive(1'b0, 32'd0, 1'b1, 1'b0, 16'd7, 1'b0);
      $display("post-clr done: bv=%0b bb=%0b ok=%0d", bus.buf_valid, bus.buf_bank, bus.frames_ok);
      chk("post-clr frames_ok", 32'(bus.frames_ok), 32'd1);
      chk("post-clr buf_bank", 32'(bus.buf_bank), 32'd0);
      chk("post-clr buf_words", 32'(bus.buf_words), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
